// File: rtl/fft_pkg.sv
// Shared FFT datapath defaults and the sample framer state encoding.
// Used by the framer, its sample banks and N_point_fft_seq.
package fft_pkg;

  localparam int SAMPLES = 16;
  localparam int WIDTH   = 32;

  typedef logic [WIDTH-1:0] sample_t;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } framer_state_e;

endpackage

// File: rtl/sample_bank.sv
// One SAMPLES x WIDTH register bank: single indexed write per cycle,
// whole bank visible in parallel for the FFT frame.
module sample_bank #(
  parameter  int SAMPLES = fft_pkg::SAMPLES,
  parameter  int WIDTH   = fft_pkg::WIDTH,
  localparam int IDX_W   = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout [SAMPLES]
);

  logic [WIDTH-1:0] mem [SAMPLES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SAMPLES; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= din;
    end
  end

  assign dout = mem;

endmodule

// File: rtl/fft_sample_framer.sv
// Packs a serial valid/ready sample stream into SAMPLES-wide frames for the FFT,
// double-buffered so the next frame fills while the current one is held.
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting samples into bank[fill_sel]
// WAIT  | fill bank complete, presented bank still owned by the FFT
module fft_sample_framer #(
  parameter int SAMPLES      = fft_pkg::SAMPLES,
  parameter int WIDTH        = fft_pkg::WIDTH,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] frame [SAMPLES],
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [15:0]      drop_count
);

  import fft_pkg::*;

  localparam int               IDX_W    = $clog2(SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  framer_state_e    state;
  framer_state_e    state_nxt;
  logic             fill_sel;
  logic [IDX_W-1:0] fill_idx;
  logic             accept;
  logic             last_accept;
  logic             handshake;
  logic             swap;
  logic             drop_event;
  logic             we0;
  logic             we1;
  logic [WIDTH-1:0] rd0 [SAMPLES];
  logic [WIDTH-1:0] rd1 [SAMPLES];

  assign handshake   = frame_valid && frame_ready;
  assign accept      = in_valid && in_ready && (state == FILL);
  assign last_accept = accept && (fill_idx == LAST_IDX);
  assign drop_event  = DROP_ON_FULL && (state == WAIT) && in_valid && (drop_count != 16'hFFFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (last_accept && frame_valid && !frame_ready) state_nxt = WAIT;
      WAIT: if (handshake) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // A swap hands the just-filled bank to the FFT; it needs the presented bank free.
  always_comb begin
    in_ready = DROP_ON_FULL ? 1'b1 : (state == FILL);
    swap     = 1'b0;
    case (state)
      FILL: swap = last_accept && (!frame_valid || frame_ready);
      WAIT: swap = handshake;
      default: swap = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_sel    <= 1'b0;
      fill_idx    <= '0;
      frame_valid <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (swap) fill_sel <= ~fill_sel;
      if (accept) fill_idx <= fill_idx + IDX_W'(1);
      if (swap) begin
        frame_valid <= 1'b1;
      end else if (handshake) begin
        frame_valid <= 1'b0;
      end
      if (drop_event) drop_count <= drop_count + 16'd1;
    end
  end

  assign we0 = accept && !fill_sel;
  assign we1 = accept && fill_sel;

  sample_bank #(
    .SAMPLES (SAMPLES),
    .WIDTH   (WIDTH)
  ) u_bank0 (
    .clk  (clk),
    .rst  (rst),
    .we   (we0),
    .idx  (fill_idx),
    .din  (in_sample),
    .dout (rd0)
  );

  sample_bank #(
    .SAMPLES (SAMPLES),
    .WIDTH   (WIDTH)
  ) u_bank1 (
    .clk  (clk),
    .rst  (rst),
    .we   (we1),
    .idx  (fill_idx),
    .din  (in_sample),
    .dout (rd1)
  );

  always_comb begin
    for (int i = 0; i < SAMPLES; i++) begin
      frame[i] = fill_sel ? rd0[i] : rd1[i];
    end
  end

endmodule

// File: doc/fft_sample_framer.md
# fft_sample_framer

Upstream feeder for `N_point_fft_seq`. It accepts a serial stream of audio samples over a valid/ready handshake and packs every `SAMPLES` consecutive accepted samples into one parallel frame. The frame is presented on an unpacked array that drives the FFT's `sampleInputs`. Double-buffering lets the next frame fill while the FFT holds the current one; the block either back-pressures or drops samples when both banks are occupied.

## Interface
- `SAMPLES`, 16: samples per frame (power of two, ≥2); must match the FFT's `SAMPLES`.
- `WIDTH`, 32: sample width in bits; must match the FFT's `WIDTH`.
- `DROP_ON_FULL`, 0: 0 = back-pressure the source when both banks are full; 1 = keep `in_ready` high and discard samples.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_sample`  in  WIDTH  incoming sample.
- `in_valid`  in  1  `in_sample` is valid.
- `in_ready`  out  1  block can accept (or, in drop mode, discard) a sample this cycle.
- `frame`  out  [WIDTH-1:0] x [SAMPLES-1:0]  presented frame; `frame[0]` is the oldest sample.
- `frame_valid`  out  1  `frame` holds a complete frame.
- `frame_ready`  in  1  FFT consumes the frame this cycle.
- `drop_count`  out  16  saturating count of discarded samples (drop mode only).

## Operation
- Storage is two banks of `SAMPLES` x `WIDTH` each, plus 1-bit `fill_sel` and a `$clog2(SAMPLES)`-bit `fill_idx`.
- `frame` always reflects bank `~fill_sel`.
- An input accept is `in_valid && in_ready` while the state is FILL. It writes `bank[fill_sel][fill_idx]` and increments `fill_idx`.
- States:
  - FILL: accepting samples into the fill bank.
  - WAIT: fill bank complete, present bank still occupied.
- Transitions on the accept of the sample at `fill_idx == SAMPLES-1`:
  - if the present bank is free (`!frame_valid`, or `frame_valid && frame_ready` this same cycle): toggle `fill_sel`, `fill_idx` wraps to 0, `frame_valid` is 1 next cycle, state stays FILL;
  - otherwise go to WAIT, with `fill_idx` held at its wrapped value 0.
- In WAIT, a `frame_valid && frame_ready` handshake toggles `fill_sel`, keeps `frame_valid` at 1 (new frame), and returns to FILL.
- A frame handshake in FILL with no swap that cycle clears `frame_valid`.
- `frame` contents are stable whenever `frame_valid` is 1 and no handshake occurs.
- `in_ready`:
  - `DROP_ON_FULL == 0`: `in_ready = (state == FILL)`.
  - `DROP_ON_FULL == 1`: constant 1 out of reset. In WAIT, each `in_valid` increments `drop_count`, saturating at 0xFFFF, and the sample is not stored.
- Samples are stored verbatim; no arithmetic on data.

## Timing
- Reset (`rst` low, asynchronous): state FILL, `fill_sel` 0, `fill_idx` 0, both banks 0, `frame_valid` 0, `drop_count` 0. `in_ready` is 1 in both modes; `frame` is all 0.
- Latency: last sample accepted at edge t gives `frame_valid` high and the new `frame` visible after edge t.
- Minimum frame period is `SAMPLES` cycles; with `frame_ready` tied high there are no stalls and no drops.
- Reset asserted mid-fill or mid-WAIT discards all partial and pending frames immediately; the first frame after release is built from the next `SAMPLES` accepted samples.
- `frame_ready` with `frame_valid` low is ignored.

## Structure
- Shared package `fft_pkg` holds:
  - `SAMPLES`/`WIDTH` defaults, also used by `N_point_fft_seq` and the top;
  - the `sample_t` typedef (`logic [WIDTH-1:0]`);
  - the framer state enum {FILL, WAIT}.
- One natural sub-module, `sample_bank`: a single `SAMPLES` x `WIDTH` register bank with write-enable/index and parallel read-out, instantiated twice.

## Test plan
- Ramp: after reset, 16 back-to-back samples 0,100,…,1500 with `frame_ready` low → `frame_valid` rises the cycle after sample 1500; `frame[i] == 100*i`.
- Steady stream: `frame_ready` tied high, 48 samples 0..47 → three frames with `frame[0]` = 0, 16, 32; `frame_valid` pulses one cycle per frame; `in_ready` never drops.
- Back-pressure (`DROP_ON_FULL=0`, `frame_ready` low): 40 samples offered → `in_ready` falls after the 32nd accept. Assert `frame_ready` for one cycle → `frame` switches to samples 16..31 and `in_ready` returns to 1.
- Drop mode (`DROP_ON_FULL=1`, `frame_ready` low): 40 samples → `drop_count == 8`, first frame holds 0..15, second frame holds 16..31.
- Simultaneous: `frame_ready` asserted in the same cycle the 16th sample of frame 2 is accepted → `frame_valid` stays 1 and `frame` changes to frame 2 on the next cycle.
- Reset mid-fill: assert `rst` low after 7 samples → all outputs at reset values immediately; the next 16 samples form a clean first frame.
